dsram_responder: RTL and testbench

DSRAM_RESPONDER -- requirements
Module: dsram_responder

---
 rtl/dsram_pkg.sv | 25 ++
 rtl/sram_if.sv | 24 ++
 rtl/dsram_bank.sv | 41 ++++
 rtl/width_param.sv | 7 +
 rtl/dsram_responder.sv | 110 +++++++++++
 tb/tb_dsram_responder.sv | 184 ++++++++++++++++++
 6 files changed

// File: rtl/dsram_pkg.sv
// rtl/dsram_pkg.sv - FSM state enum and byte-mask expansion shared by the data-SRAM responder
`ifndef DATA_WIDTH
`include "width_param.sv"
`endif

package dsram_pkg;

  localparam int BYTE_W = `DATA_WIDTH / `NUM_OF_BYTES;

  typedef enum logic [1:0] {
    DSRAM_RESET,
    DSRAM_CLEAR,
    DSRAM_READY
  } dsram_state_e;

  function automatic logic [`DATA_WIDTH-1:0] expand_mask(input logic [`NUM_OF_BYTES-1:0] mask);
    logic [`DATA_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < `NUM_OF_BYTES; i++) begin
      m[i*BYTE_W +: BYTE_W] = {BYTE_W{mask[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/sram_if.sv
// rtl/sram_if.sv - data-SRAM request/response bundle; s is the responder end, m the requester end
`ifndef DATA_WIDTH
`include "width_param.sv"
`endif

interface sram_if;
  logic                       sram_rd_en;
  logic [`ADDR_WIDTH-1:0]     sram_rd_addr;
  logic [`DATA_WIDTH-1:0]     sram_rd_data;
  logic                       sram_wr_en;
  logic [`ADDR_WIDTH-1:0]     sram_wr_addr;
  logic [`DATA_WIDTH-1:0]     sram_wr_data;
  logic [`NUM_OF_BYTES-1:0]   sram_wr_mask;

  modport s (
    input  sram_rd_en, sram_rd_addr, sram_wr_en, sram_wr_addr, sram_wr_data, sram_wr_mask,
    output sram_rd_data
  );

  modport m (
    output sram_rd_en, sram_rd_addr, sram_wr_en, sram_wr_addr, sram_wr_data, sram_wr_mask,
    input  sram_rd_data
  );
endinterface

// File: rtl/dsram_bank.sv
// rtl/dsram_bank.sv - DEPTH_WORDS x 32 storage: combinational read port, byte-masked write port, multi-word clear port
`ifndef DATA_WIDTH
`include "width_param.sv"
`endif

module dsram_bank
  import dsram_pkg::*;
#(
  parameter int DEPTH_WORDS = 16384,
  parameter int CLEAR_STEP  = 1
) (
  input  logic                             clk,
  input  logic [$clog2(DEPTH_WORDS)-1:0]   rd_idx,
  output logic [`DATA_WIDTH-1:0]           rd_word,
  input  logic                             wr_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0]   wr_idx,
  input  logic [`DATA_WIDTH-1:0]           wr_data,
  input  logic [`NUM_OF_BYTES-1:0]         wr_mask,
  input  logic                             clr_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0]   clr_idx
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [`DATA_WIDTH-1:0] mem [DEPTH_WORDS];
  logic [`DATA_WIDTH-1:0] wr_bits;

  assign wr_bits = expand_mask(wr_mask);
  assign rd_word = mem[rd_idx];

  // No reset on the array: contents are only ever zeroed by the clear port.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      for (int i = 0; i < CLEAR_STEP; i++) begin
        mem[clr_idx + IDX_W'(i)] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_idx] <= (mem[wr_idx] & ~wr_bits) | (wr_data & wr_bits);
    end
  end

endmodule

// File: rtl/width_param.sv
// rtl/width_param.sv - shared bus width macros for the data-SRAM slice
`ifndef WIDTH_PARAM_SV
`define WIDTH_PARAM_SV
`define DATA_WIDTH   32
`define ADDR_WIDTH   32
`define NUM_OF_BYTES 4
`endif

// File: rtl/dsram_responder.sv
// rtl/dsram_responder.sv - data-SRAM responder: reset/clear FSM, request gating, write-first forwarding
// Optional zero-fill sweep after reset is built only with DSRAM_ZERO_INIT_EN defined.
`ifndef DATA_WIDTH
`include "width_param.sv"
`endif

module dsram_responder
  import dsram_pkg::*;
#(
  parameter int DEPTH_WORDS = 16384,
  parameter int CLEAR_STEP  = 1
) (
  input  logic clk,
  input  logic rst_n,
  sram_if.s    sram_io,
  output logic busy
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  dsram_state_e state_q, state_d;

  logic [IDX_W-1:0]         rd_idx, wr_idx, clr_idx;
  logic                     rd_go, wr_go, clr_en;
  logic [`DATA_WIDTH-1:0]   bank_word, wr_bits, fwd_word;
  logic                     unused_addr_bits;

  assign rd_idx = sram_io.sram_rd_addr[IDX_W+1:2];
  assign wr_idx = sram_io.sram_wr_addr[IDX_W+1:2];
  assign unused_addr_bits = ^{sram_io.sram_rd_addr[`ADDR_WIDTH-1:IDX_W+2], sram_io.sram_rd_addr[1:0],
                              sram_io.sram_wr_addr[`ADDR_WIDTH-1:IDX_W+2], sram_io.sram_wr_addr[1:0]};

  assign busy  = (state_q != DSRAM_READY);
  assign rd_go = sram_io.sram_rd_en & ~busy;
  assign wr_go = sram_io.sram_wr_en & ~busy;

`ifdef DSRAM_ZERO_INIT_EN
  logic [IDX_W-1:0] sweep_q;
  logic             sweep_last;

  assign sweep_last = (sweep_q == IDX_W'(DEPTH_WORDS - CLEAR_STEP));
  assign clr_en     = (state_q == DSRAM_CLEAR);
  assign clr_idx    = sweep_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_q <= '0;
    end else if (state_q == DSRAM_CLEAR) begin
      sweep_q <= sweep_q + IDX_W'(CLEAR_STEP);
    end else begin
      sweep_q <= '0;
    end
  end
`else
  assign clr_en  = 1'b0;
  assign clr_idx = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DSRAM_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
`ifdef DSRAM_ZERO_INIT_EN
      DSRAM_RESET: state_d = DSRAM_CLEAR;
      DSRAM_CLEAR: if (sweep_last) state_d = DSRAM_READY;
`else
      DSRAM_RESET: state_d = DSRAM_READY;
      DSRAM_CLEAR: state_d = DSRAM_READY;
`endif
      DSRAM_READY: state_d = DSRAM_READY;
      default:     state_d = DSRAM_RESET;
    endcase
  end

  dsram_bank #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .CLEAR_STEP  (CLEAR_STEP)
  ) u_bank (
    .clk     (clk),
    .rd_idx  (rd_idx),
    .rd_word (bank_word),
    .wr_en   (wr_go),
    .wr_idx  (wr_idx),
    .wr_data (sram_io.sram_wr_data),
    .wr_mask (sram_io.sram_wr_mask),
    .clr_en  (clr_en),
    .clr_idx (clr_idx)
  );

  // Same-word collision returns the post-write word, lane by lane.
  assign wr_bits  = expand_mask(sram_io.sram_wr_mask);
  assign fwd_word = (wr_go && (wr_idx == rd_idx))
                  ? ((bank_word & ~wr_bits) | (sram_io.sram_wr_data & wr_bits))
                  : bank_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_io.sram_rd_data <= '0;
    end else if (rd_go) begin
      sram_io.sram_rd_data <= fwd_word;
    end
  end

endmodule

// File: tb/tb_dsram_responder.sv
// tb/tb_dsram_responder.sv - directed bench for dsram_responder (DEPTH_WORDS=16, CLEAR_STEP=1)
module tb_dsram_responder;

  localparam int DW = 16;
  localparam int CS = 1;
`ifdef DSRAM_ZERO_INIT_EN
  localparam int BUSY_CYC = 1 + DW / CS;
`else
  localparam int BUSY_CYC = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   tests = 0;
  int   fails = 0;

  sram_if bus ();

  dsram_responder #(
    .DEPTH_WORDS (DW),
    .CLEAR_STEP  (CS)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sram_io (bus),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_bus();
    bus.sram_rd_en   = 1'b0;
    bus.sram_wr_en   = 1'b0;
    bus.sram_wr_mask = 4'h0;
  endtask

  // Called at a negedge; returns at a later negedge.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    bus.sram_wr_en   = 1'b1;
    bus.sram_wr_addr = a;
    bus.sram_wr_data = d;
    bus.sram_wr_mask = m;
    @(negedge clk);
    idle_bus();
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d);
    bus.sram_rd_en   = 1'b1;
    bus.sram_rd_addr = a;
    @(negedge clk);
    bus.sram_rd_en   = 1'b0;
    d = bus.sram_rd_data;
  endtask

  // Releases reset and counts sampled busy cycles; optionally pokes requests while busy.
  task automatic release_and_count(input bit poke, output int n);
    rst_n = 1'b1;
    if (poke) begin
      bus.sram_wr_en   = 1'b1;
      bus.sram_wr_addr = 32'h0;
      bus.sram_wr_data = 32'hDEADBEEF;
      bus.sram_wr_mask = 4'hF;
      bus.sram_rd_en   = 1'b1;
      bus.sram_rd_addr = 32'h0;
    end
    n = 0;
    #1;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    idle_bus();
  endtask

  logic [31:0] rd;
  logic [31:0] exp_w0;
  int          nb;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_bus();
    bus.sram_rd_addr = '0;
    bus.sram_wr_addr = '0;
    bus.sram_wr_data = '0;
    repeat (3) @(negedge clk);
    check("reset_rd_data", bus.sram_rd_data, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h1);

    release_and_count(1'b0, nb);
    check("busy_cycles", nb, BUSY_CYC);
`ifdef DSRAM_ZERO_INIT_EN
    for (int i = 0; i < DW; i++) begin
      do_read(i * 4, rd);
      check($sformatf("clear_word%0d", i), rd, 32'h0);
    end
`endif

    do_write(32'h10, 32'hAABBCCDD, 4'b1111);
    do_write(32'h10, 32'h00EE0000, 4'b0100);
    do_read(32'h10, rd);
    check("masked_write", rd, 32'hAAEECCDD);

    do_write(32'h20, 32'h11223344, 4'b1111);
    bus.sram_rd_en   = 1'b1;
    bus.sram_rd_addr = 32'h20;
    do_write(32'h20, 32'h000000FF, 4'b0001);
    bus.sram_rd_en = 1'b0;
    check("same_word_fwd", bus.sram_rd_data, 32'h112233FF);
    do_read(32'h20, rd);
    check("same_word_stored", rd, 32'h112233FF);

    do_write(32'h40, 32'h5, 4'b1111);
    do_read(32'h0, rd);
    check("wrap_read", rd, 32'h5);
    for (int i = 0; i < 3; i++) begin
      bus.sram_rd_addr = 32'h10;
      do_write(32'h8, 32'h0BAD0000 + i, 4'hF);
      check($sformatf("hold_%0d", i), bus.sram_rd_data, 32'h5);
    end

    bus.sram_rd_en   = 1'b1;
    bus.sram_rd_addr = 32'h10;
    do_write(32'h4, 32'hCAFEF00D, 4'hF);
    bus.sram_rd_en = 1'b0;
    check("diff_word_read", bus.sram_rd_data, 32'hAAEECCDD);
    do_read(32'h1007, rd);
    check("diff_word_write_hi_addr", rd, 32'hCAFEF00D);
    do_read(32'h1013, rd);
    check("addr_ignored_bits", rd, 32'hAAEECCDD);
    do_write(32'h4, 32'hFFFFFFFF, 4'b0000);
    do_read(32'h4, rd);
    check("zero_mask_write", rd, 32'hCAFEF00D);

    // Reset in the middle of the sweep (or of a read stream without the sweep).
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.sram_rd_en   = 1'b1;
    bus.sram_rd_addr = 32'h10;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midsweep_rd_data", bus.sram_rd_data, 32'h0);
    check("midsweep_busy", {31'b0, busy}, 32'h1);
    bus.sram_rd_en = 1'b0;
    @(negedge clk);
    release_and_count(1'b0, nb);
    check("midsweep_busy_cycles", nb, BUSY_CYC);
`ifdef DSRAM_ZERO_INIT_EN
    do_read(32'h10, rd);
    check("midsweep_full_clear", rd, 32'h0);
    exp_w0 = 32'h0;
`else
    exp_w0 = 32'h5;
`endif

    // Requests presented while busy must be dropped.
    rst_n = 1'b0;
    @(negedge clk);
    release_and_count(1'b1, nb);
    check("ignored_busy_cycles", nb, BUSY_CYC);
    check("ignored_rd_data", bus.sram_rd_data, 32'h0);
    do_read(32'h0, rd);
    check("ignored_write", rd, exp_w0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
